// File: rtl/memory_port_arbiter.sv
// Round-robin arbiter sharing one registered memory port among N requesters.
// Read responses are routed back to their issuer through a ReadLatency-deep tag pipe.
module memory_port_arbiter #(
    parameter int ParamNumRequesters = 4,
    parameter int AddrWidth          = 32,
    parameter int DataWidth          = 32,
    parameter int ReadLatency        = 1
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic [ParamNumRequesters-1:0]           req_valid,
    input  logic [ParamNumRequesters-1:0]           req_write,
    input  logic [ParamNumRequesters*AddrWidth-1:0] req_addr,
    input  logic [ParamNumRequesters*DataWidth-1:0] req_wdat,
    output logic [ParamNumRequesters-1:0]           req_ready,
    output logic [AddrWidth-1:0]                    mem_addr,
    output logic [DataWidth-1:0]                    mem_wdat,
    output logic                                    mem_we,
    output logic                                    mem_re,
    input  logic [DataWidth-1:0]                    mem_rdat,
    output logic [ParamNumRequesters-1:0]           rsp_valid,
    output logic [DataWidth-1:0]                    rsp_data
);

    localparam int N    = ParamNumRequesters;
    localparam int IdxW = (N > 1) ? $clog2(N) : 1;

    logic [IdxW-1:0]      ptr_q, ptr_d;
    logic                 grant_vld;
    logic [IdxW-1:0]      grant_idx;

    logic [AddrWidth-1:0] mem_addr_q, mem_addr_d;
    logic [DataWidth-1:0] mem_wdat_q, mem_wdat_d;
    logic                 mem_we_q, mem_we_d;
    logic                 mem_re_q, mem_re_d;
    logic [IdxW-1:0]      mem_idx_q;

    logic [ReadLatency-1:0]           tag_vld_q;
    logic [ReadLatency-1:0][IdxW-1:0] tag_idx_q;

    // Two descending passes: the second (indices at or above ptr) overrides the
    // first, so the lowest valid index at/after ptr wins, else the lowest below it.
    always_comb begin
        // NOTE: combinational blocks use blocking assignments and default every
        // output first, so no path leaves a value unassigned and infers a latch.
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_valid[i] && (i < int'(ptr_q))) begin
                grant_vld = 1'b1;
                grant_idx = IdxW'(i);
            end
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (req_valid[i] && (i >= int'(ptr_q))) begin
                grant_vld = 1'b1;
                grant_idx = IdxW'(i);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N; i++) begin
            req_ready[i] = reset_n && grant_vld && (grant_idx == IdxW'(i));
        end
    end

    always_comb begin
        ptr_d      = ptr_q;
        mem_addr_d = mem_addr_q;
        mem_wdat_d = mem_wdat_q;
        mem_we_d   = 1'b0;
        mem_re_d   = 1'b0;
        if (grant_vld) begin
            ptr_d = (grant_idx == IdxW'(N - 1)) ? '0 : grant_idx + IdxW'(1);
        end
        for (int i = 0; i < N; i++) begin
            if (grant_vld && (grant_idx == IdxW'(i))) begin
                mem_addr_d = req_addr[i*AddrWidth +: AddrWidth];
                mem_wdat_d = req_wdat[i*DataWidth +: DataWidth];
                mem_we_d   = req_write[i];
                mem_re_d   = !req_write[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: clocked state uses non-blocking assignments so every flop samples
        // pre-edge values regardless of statement order.
        if (!reset_n) begin
            ptr_q      <= '0;
            mem_addr_q <= '0;
            mem_wdat_q <= '0;
            mem_we_q   <= 1'b0;
            mem_re_q   <= 1'b0;
            tag_vld_q  <= '0;
        end else begin
            ptr_q        <= ptr_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdat_q   <= mem_wdat_d;
            mem_we_q     <= mem_we_d;
            mem_re_q     <= mem_re_d;
            tag_vld_q[0] <= mem_re_q;
            for (int s = 1; s < ReadLatency; s++) begin
                tag_vld_q[s] <= tag_vld_q[s-1];
            end
        end
    end

    // NOTE: the requester tags need no reset; they are only looked at when the
    // matching valid bit, which is reset, is set.
    always_ff @(posedge clk) begin
        mem_idx_q    <= grant_idx;
        tag_idx_q[0] <= mem_idx_q;
        for (int s = 1; s < ReadLatency; s++) begin
            tag_idx_q[s] <= tag_idx_q[s-1];
        end
    end

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < N; i++) begin
            rsp_valid[i] = tag_vld_q[ReadLatency-1] && (tag_idx_q[ReadLatency-1] == IdxW'(i));
        end
    end

    assign rsp_data = mem_rdat;
    assign mem_addr = mem_addr_q;
    assign mem_wdat = mem_wdat_q;
    assign mem_we   = mem_we_q;
    assign mem_re   = mem_re_q;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed and randomized checks of memory_port_arbiter against a cycle-level
// model of round-robin grants, registered port outputs and in-order read returns.
module tb_memory_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int RL = 2;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req_valid, req_write, req_ready, rsp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdat;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdat, mem_rdat, rsp_data;
    logic            mem_we, mem_re;

    always #5 clk = ~clk;

    memory_port_arbiter #(
        .ParamNumRequesters(N),
        .AddrWidth         (AW),
        .DataWidth         (DW),
        .ReadLatency       (RL)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req_valid(req_valid),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdat (req_wdat),
        .req_ready(req_ready),
        .mem_addr (mem_addr),
        .mem_wdat (mem_wdat),
        .mem_we   (mem_we),
        .mem_re   (mem_re),
        .mem_rdat (mem_rdat),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data)
    );

    function automatic logic [DW-1:0] init_val(input int a);
        logic [7:0] b;
        b = 8'(a);
        return {b, ~b};
    endfunction

    // Memory device: read data appears RL cycles after the cycle mem_re is high.
    logic [DW-1:0] dev_mem [256];
    bit            dev_written [256];
    logic [DW-1:0] rd_dl [RL];

    always @(posedge clk) begin
        if (mem_we) begin
            dev_mem[mem_addr]     <= mem_wdat;
            dev_written[mem_addr] <= 1'b1;
        end
        if (mem_re)
            rd_dl[0] <= dev_written[mem_addr] ? dev_mem[mem_addr] : init_val(int'(mem_addr));
        else
            rd_dl[0] <= DW'($urandom);
        for (int s = 1; s < RL; s++) rd_dl[s] <= rd_dl[s-1];
    end
    assign mem_rdat = rd_dl[RL-1];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Requester commands, held until granted.
    bit            cmd_v [N];
    bit            cmd_w [N];
    logic [AW-1:0] cmd_a [N];
    logic [DW-1:0] cmd_d [N];

    // Reference model state.
    typedef struct {
        int            cyc;
        int            idx;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          rq[$];
    int            cyc = 0;
    int            m_ptr;
    logic          m_we, m_re;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdat;
    logic [DW-1:0] m_mem [256];

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            req_valid[i]           = cmd_v[i];
            req_write[i]           = cmd_w[i];
            req_addr[i*AW +: AW]   = cmd_a[i];
            req_wdat[i*DW +: DW]   = cmd_d[i];
        end
    endtask

    task automatic set_cmd(input int i, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_v[i] = 1'b1;
        cmd_w[i] = w;
        cmd_a[i] = a;
        cmd_d[i] = d;
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_we   = 1'b0;
        m_re   = 1'b0;
        m_addr = '0;
        m_wdat = '0;
        rq.delete();
    endtask

    // One clock cycle: apply commands, compare everything, advance the model.
    task automatic step(output int win);
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_rsp;
        drive_inputs();
        #1;
        win = -1;
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (win < 0 && cmd_v[c]) win = c;
        end
        exp_rdy = (win >= 0) ? (N'(1) << win) : '0;
        check("req_ready", req_ready, exp_rdy);
        check("mem_we", mem_we, m_we);
        check("mem_re", mem_re, m_re);
        check("mem_addr", mem_addr, m_addr);
        check("mem_wdat", mem_wdat, m_wdat);
        exp_rsp = '0;
        if (rq.size() > 0 && rq[0].cyc == cyc) begin
            exp_rsp = N'(1) << rq[0].idx;
            check("rsp_data", rsp_data, rq[0].data);
            void'(rq.pop_front());
        end
        check("rsp_valid", rsp_valid, exp_rsp);
        if (win >= 0) begin
            m_ptr  = (win + 1) % N;
            m_we   = cmd_w[win];
            m_re   = !cmd_w[win];
            m_addr = cmd_a[win];
            m_wdat = cmd_d[win];
            if (cmd_w[win]) m_mem[cmd_a[win]] = cmd_d[win];
            else rq.push_back('{cyc + 1 + RL, win, m_mem[cmd_a[win]]});
            cmd_v[win] = 1'b0;
        end else begin
            m_we = 1'b0;
            m_re = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        int w;
        for (int i = 0; i < n; i++) step(w);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_mem_re"}, mem_re, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wdat"}, mem_wdat, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
    endtask

    initial begin
        int w;
        for (int a = 0; a < 256; a++) m_mem[a] = init_val(a);
        for (int i = 0; i < N; i++) set_cmd(i, 1'b0, AW'(i * 4), DW'(0));
        model_reset();

        // Reset with every requester already valid: nothing may be granted.
        reset_n = 1'b0;
        drive_inputs();
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Continuous contention from reset: grants 0,1,2,3,0 then 1.
        for (int k = 0; k < 6; k++) begin
            step(w);
            check("contention_order", w, (k % N));
            if (w >= 0) set_cmd(w, 1'b0, AW'($urandom_range(0, 255)), DW'(0));
        end
        for (int i = 0; i < N; i++) cmd_v[i] = 1'b0;
        idle(5);

        // Single read from requester 2.
        set_cmd(2, 1'b0, 8'h10, 16'h0000);
        idle(5);

        // Write from requester 0, then read it back from requester 1.
        set_cmd(0, 1'b1, 8'h3F, 16'hBEEF);
        idle(5);
        set_cmd(1, 1'b0, 8'h3F, 16'h0000);
        idle(5);

        // Back-to-back reads from requesters 1 and 3.
        set_cmd(1, 1'b0, 8'h21, 16'h0000);
        step(w);
        set_cmd(3, 1'b0, 8'h33, 16'h0000);
        idle(6);

        // Grant to 2, idle three cycles, then all valid: 3 must win.
        set_cmd(2, 1'b0, 8'h44, 16'h0000);
        idle(4);
        for (int i = 0; i < N; i++) set_cmd(i, 1'b0, AW'(8'h50 + i), DW'(0));
        step(w);
        check("ptr_after_idle", w, 3);
        idle(8);

        // Reset one cycle after a read is granted: the read must vanish.
        set_cmd(0, 1'b0, 8'h60, 16'h0000);
        step(w);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        idle(6);

        // Randomized traffic with writes and reads over a small address window.
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!cmd_v[i] && $urandom_range(0, 1) == 1)
                    set_cmd(i, ($urandom_range(0, 9) < 3), AW'($urandom_range(0, 31)), DW'($urandom));
            end
            step(w);
        end
        for (int i = 0; i < N; i++) cmd_v[i] = 1'b0;
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
